// File: rtl/mod_exp_pkg.sv
// Shared types for the square-and-multiply modular exponentiation sequencer.
// State encodings are fixed so waveforms and downstream tooling stay stable.
package mod_exp_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SCAN      = 3'd1,
        NEXT      = 3'd2,
        SQR_ISSUE = 3'd3,
        SQR_WAIT  = 3'd4,
        MUL_ISSUE = 3'd5,
        MUL_WAIT  = 3'd6,
        DONE      = 3'd7
    } state_t;

    function automatic int cw_f(input int ebits);
        return $clog2(ebits + 1);
    endfunction

endpackage

// File: rtl/mod_exp_sqm_ctrl_bit_iter.sv
// Exponent iterator: MSB-first shift register plus count of bits still to visit.
module mod_exp_bit_iter
    import mod_exp_pkg::*;
#(
    parameter int EBITS = 4096,
    parameter int CW    = cw_f(EBITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [EBITS-1:0] exp_i,
    output logic             cur_bit_o,
    output logic             last_o
);

    logic [EBITS-1:0] e_q;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            e_q   <= exp_i;
            cnt_q <= CW'(EBITS);
        end else if (shift_i) begin
            e_q   <= {e_q[EBITS-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign cur_bit_o = e_q[EBITS-1];
    assign last_o    = (cnt_q == '0);

endmodule

// File: rtl/mod_exp_sqm_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external modular multiplier.
// Define MOD_EXP_CONST_TIME_EN for fixed 2*EBITS multiplications (no data-dependent timing).
module mod_exp_sqm_ctrl
    import mod_exp_pkg::*;
#(
    parameter int NBITS = 4096,
    parameter int EBITS = 4096,
    parameter int CW    = cw_f(EBITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic [NBITS-1:0] base,
    input  logic [EBITS-1:0] exp,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] y,
    output logic             done_irq_p,
    output logic             busy,
    output logic             mul_enable_p,
    output logic [NBITS-1:0] mul_a,
    output logic [NBITS-1:0] mul_b,
    output logic [NBITS-1:0] mul_m,
    input  logic [NBITS-1:0] mul_y,
    input  logic             mul_done_irq_p
);

    state_t           state_q, state_d;
    logic [NBITS-1:0] r_q, r_d, b_q, m_q, y_q, y_d;
    logic [NBITS-1:0] ma_q, ma_d, mb_q, mb_d, mm_q, mm_d;
    logic             done_q, done_d, men_q, men_d;
    logic             load, shift, cur_bit, last;

    mod_exp_bit_iter #(.EBITS(EBITS), .CW(CW)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load),
        .shift_i   (shift),
        .exp_i     (exp),
        .cur_bit_o (cur_bit),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: if (enable_p) begin
                load    = 1'b1;
                state_d = SCAN;
            end
`ifdef MOD_EXP_CONST_TIME_EN
            SCAN: begin
                r_d     = NBITS'(1);
                state_d = NEXT;
            end
`else
            SCAN: if (last) begin
                r_d     = NBITS'(1);
                state_d = DONE;
            end else if (cur_bit) begin
                r_d     = b_q;
                shift   = 1'b1;
                state_d = NEXT;
            end else begin
                shift   = 1'b1;
            end
`endif
            NEXT:      state_d = last ? DONE : SQR_ISSUE;
            SQR_ISSUE: state_d = SQR_WAIT;
            SQR_WAIT: if (mul_done_irq_p) begin
                r_d = mul_y;
`ifdef MOD_EXP_CONST_TIME_EN
                state_d = MUL_ISSUE;
`else
                if (cur_bit) begin
                    state_d = MUL_ISSUE;
                end else begin
                    shift   = 1'b1;
                    state_d = NEXT;
                end
`endif
            end
            MUL_ISSUE: state_d = MUL_WAIT;
            MUL_WAIT: if (mul_done_irq_p) begin
                // In constant-time mode the multiply always runs but only a 1 bit keeps its product.
`ifdef MOD_EXP_CONST_TIME_EN
                if (cur_bit) r_d = mul_y;
`else
                r_d = mul_y;
`endif
                shift   = 1'b1;
                state_d = NEXT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are loaded on entry to an ISSUE state and held until the next ISSUE.
    always_comb begin
        ma_d   = ma_q;
        mb_d   = mb_q;
        mm_d   = mm_q;
        men_d  = 1'b0;
        done_d = (state_d == DONE);
        y_d    = done_d ? r_d : y_q;
        if (state_d == SQR_ISSUE) begin
            ma_d  = r_d;
            mb_d  = r_d;
            mm_d  = m_q;
            men_d = 1'b1;
        end else if (state_d == MUL_ISSUE) begin
            ma_d  = r_d;
            mb_d  = b_q;
            mm_d  = m_q;
            men_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            y_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            mm_q    <= '0;
            done_q  <= 1'b0;
            men_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            y_q     <= y_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            mm_q    <= mm_d;
            done_q  <= done_d;
            men_q   <= men_d;
            if (load) begin
                b_q <= base;
                m_q <= m;
            end
        end
    end

    assign y            = y_q;
    assign done_irq_p   = done_q;
    assign busy         = (state_q != IDLE);
    assign mul_enable_p = men_q;
    assign mul_a        = ma_q;
    assign mul_b        = mb_q;
    assign mul_m        = mm_q;

endmodule

// File: tb/tb_mod_exp_sqm_ctrl.sv
// Directed bench for mod_exp_sqm_ctrl with a 20-cycle modular multiplier model.
module tb_mod_exp_sqm_ctrl;

    localparam int NB = 16;
    localparam int EB = 16;
`ifdef MOD_EXP_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable_p = 1'b0;
    logic [NB-1:0] base = '0, m = '0;
    logic [EB-1:0] exp = '0;
    logic [NB-1:0] y, mul_a, mul_b, mul_m;
    logic          done_irq_p, busy, mul_enable_p;
    logic [NB-1:0] mul_y;
    logic          mul_done_irq_p;

    always #5 clk = ~clk;

    mod_exp_sqm_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_p       (enable_p),
        .base           (base),
        .exp            (exp),
        .m              (m),
        .y              (y),
        .done_irq_p     (done_irq_p),
        .busy           (busy),
        .mul_enable_p   (mul_enable_p),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_m          (mul_m),
        .mul_y          (mul_y),
        .mul_done_irq_p (mul_done_irq_p)
    );

    // Multiplier model: captures operands on the start pulse, answers 20 cycles later.
    logic [NB-1:0] ma, mb, mmod;
    int            mcnt;
    logic          mact;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mact           <= 1'b0;
            mcnt           <= 0;
            mul_done_irq_p <= 1'b0;
            mul_y          <= '0;
            ma             <= '0;
            mb             <= '0;
            mmod           <= 16'd1;
        end else begin
            mul_done_irq_p <= 1'b0;
            if (mul_enable_p) begin
                ma   <= mul_a;
                mb   <= mul_b;
                mmod <= mul_m;
                mcnt <= 20;
                mact <= 1'b1;
            end else if (mact) begin
                if (mcnt == 1) begin
                    mul_y          <= NB'((32'(ma) * 32'(mb)) % 32'(mmod));
                    mul_done_irq_p <= 1'b1;
                    mact           <= 1'b0;
                end
                mcnt <= mcnt - 1;
            end
        end
    end

    int mul_pulses = 0, done_pulses = 0, stab_errs = 0;
    always @(posedge clk) begin
        if (mul_enable_p) mul_pulses <= mul_pulses + 1;
        if (done_irq_p)   done_pulses <= done_pulses + 1;
        if (rst_n && mact && !mul_enable_p &&
            (mul_a != ma || mul_b != mb || mul_m != mmod))
            stab_errs <= stab_errs + 1;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Runs one exponentiation; inj=1 re-pulses enable_p with other operands mid-SQR_WAIT.
    task automatic run_op(input logic [NB-1:0] b, input logic [EB-1:0] e, input logic [NB-1:0] mm,
                          input bit inj, output logic [NB-1:0] yv, output int muls,
                          output int dones, output int lat, output int stab);
        int m0, d0, s0, c, wait_c;
        bit injected;
        m0 = mul_pulses; d0 = done_pulses; s0 = stab_errs;
        lat = -1; c = 0; wait_c = 0; injected = 1'b0; yv = '0;
        @(negedge clk);
        base = b; exp = e; m = mm; enable_p = 1'b1;
        while (lat < 0 && c < 4000) begin
            @(negedge clk);
            c++;
            enable_p = 1'b0;
            if (done_irq_p) begin
                lat = c;
                yv  = y;
            end else if (inj && !injected && (mul_pulses - m0) >= 1) begin
                wait_c++;
                if (wait_c == 3) begin
                    base = 16'd5; exp = 16'd3; m = 16'd7; enable_p = 1'b1;
                    injected = 1'b1;
                end
            end
        end
        repeat (3) @(negedge clk);
        muls  = mul_pulses - m0;
        dones = done_pulses - d0;
        stab  = stab_errs - s0;
    endtask

    typedef struct {
        logic [NB-1:0] base;
        logic [EB-1:0] exp;
        logic [NB-1:0] m;
        logic [NB-1:0] y;
        int            muls;
    } vec_t;

    vec_t tbl [6];
    int   lat_tbl [6];

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_done"}, done_irq_p, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mul_en"}, mul_enable_p, 0);
        chk({tag, "_mul_a"}, mul_a, 0);
        chk({tag, "_mul_b"}, mul_b, 0);
        chk({tag, "_mul_m"}, mul_m, 0);
    endtask

    initial begin
        logic [NB-1:0] yv;
        int muls, dones, lat, stab, m0, c;

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        tbl[0] = '{16'd4, 16'd13,     16'd497,   16'd445,   5};
        tbl[1] = '{16'd7, 16'd0,      16'd11,    16'd1,     0};
        tbl[2] = '{16'd9, 16'd1,      16'd13,    16'd9,     0};
        tbl[3] = '{16'd3, 16'hFFFF,   16'd65521, 16'd65329, 30};
        tbl[4] = '{16'd2, 16'd10,     16'd1000,  16'd24,    4};
        tbl[5] = '{16'd5, 16'h8000,   16'd13,    16'd1,     15};

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].base, tbl[i].exp, tbl[i].m, 1'b0, yv, muls, dones, lat, stab);
            lat_tbl[i] = lat;
            chk($sformatf("v%0d_finished", i), (lat >= 0), 1);
            chk($sformatf("v%0d_y", i), yv, tbl[i].y);
            chk($sformatf("v%0d_held_y", i), y, tbl[i].y);
            chk($sformatf("v%0d_muls", i), muls, CT ? 32 : tbl[i].muls);
            chk($sformatf("v%0d_dones", i), dones, 1);
            chk($sformatf("v%0d_busy_after", i), busy, 0);
            chk($sformatf("v%0d_operand_hold", i), stab, 0);
        end
`ifdef MOD_EXP_CONST_TIME_EN
        chk("ct_latency_13_vs_8000", lat_tbl[5], lat_tbl[0]);
`else
        chk("exp0_latency", lat_tbl[1], 18);
`endif

        // Re-pulsed enable_p while busy must not disturb the running operation.
        run_op(16'd4, 16'd13, 16'd497, 1'b1, yv, muls, dones, lat, stab);
        chk("repulse_y", yv, 445);
        chk("repulse_muls", muls, CT ? 32 : 5);
        chk("repulse_dones", dones, 1);

        // Reset asserted while the second multiplication is outstanding.
        m0 = mul_pulses; c = 0;
        @(negedge clk);
        base = 16'd4; exp = 16'd13; m = 16'd497; enable_p = 1'b1;
        @(negedge clk);
        enable_p = 1'b0;
        while ((mul_pulses - m0) < 2 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("rst_reached_mul_wait", ((mul_pulses - m0) >= 2), 1);
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_idle_busy", busy, 0);
        run_op(16'd4, 16'd13, 16'd497, 1'b0, yv, muls, dones, lat, stab);
        chk("after_rst_y", yv, 445);
        chk("after_rst_muls", muls, CT ? 32 : 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
